// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage signed add/subtract with optional saturation.
// Stage 1 adds the lower half with 4-bit carry-lookahead blocks. Stage 2
// adds the upper half using the registered carry, then saturates and flags.
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Zero,
  output logic             Neg
);

  localparam int H = WIDTH / 2;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_SATADD = 2'b10,
    OP_SATSUB = 2'b11
  } op_e;

  // Adds two H-bit values using a chain of 4-bit lookahead blocks.
  // The result is {carry_out, sum}.
  function automatic logic [H:0] cla_add(input logic [H-1:0] a,
                                         input logic [H-1:0] b,
                                         input logic         cin);
    logic [H-1:0] s;
    logic [3:0]   g;
    logic [3:0]   p;
    logic [4:0]   cc;
    logic         c;
    s = '0;
    c = cin;
    for (int unsigned k = 0; k < H / 4; k++) begin
      g = a[4*k +: 4] & b[4*k +: 4];
      p = a[4*k +: 4] ^ b[4*k +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);
      s[4*k +: 4] = p ^ cc[3:0];
      c = cc[4];
    end
    return {c, s};
  endfunction

  // Stage 1 combinational signals
  op_e            op_in;
  logic           sub_in;
  logic [WIDTH-1:0] b_inv;
  logic [H:0]     lo_res;
  logic           b_sign_eff;

  // Stage 1 registers
  logic           v1;
  op_e            op1;
  logic [H-1:0]   lo1;
  logic           c1;
  logic [H-1:0]   a_hi1;
  logic [H-1:0]   b_hi1;
  logic           b_sign1;

  // Stage 2 combinational signals
  logic [H-1:0]     hi_sum;
  logic [WIDTH-1:0] raw;
  logic             ovf;
  logic [WIDTH-1:0] res;

  // Operand conditioning and lower-half lookahead add.
  always_comb begin
    op_in  = op_e'(mode);
    sub_in = (op_in == OP_SUB) || (op_in == OP_SATSUB);
    b_inv  = sub_in ? ~B : B;
    lo_res = cla_add(A[H-1:0], b_inv[H-1:0], sub_in);
    // Sign of ~B+1 without a second adder: it is 1 when B is positive, or
    // when B is the most-negative value (whose negation is itself).
    b_sign_eff = sub_in ? (B[WIDTH-1] ^ (|B[WIDTH-2:0])) : B[WIDTH-1];
  end

  // Stage 1 register: lower sum, carry, upper halves and operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      op1     <= OP_ADD;
      lo1     <= '0;
      c1      <= 1'b0;
      a_hi1   <= '0;
      b_hi1   <= '0;
      b_sign1 <= 1'b0;
    end else if (!stall) begin
      v1      <= in_valid;
      op1     <= op_in;
      lo1     <= lo_res[H-1:0];
      c1      <= lo_res[H];
      a_hi1   <= A[WIDTH-1:H];
      b_hi1   <= b_inv[WIDTH-1:H];
      b_sign1 <= b_sign_eff;
    end
  end

  // Upper-half add, overflow detection and saturation.
  always_comb begin
    hi_sum = H'(cla_add(a_hi1, b_hi1, c1));
    raw    = {hi_sum, lo1};
    ovf    = (a_hi1[H-1] == b_sign1) && (raw[WIDTH-1] != a_hi1[H-1]);
    res    = raw;
    if (ovf && (op1 == OP_SATADD || op1 == OP_SATSUB)) begin
      res = a_hi1[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Output register: results load only for valid ops, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Ovfl      <= 1'b0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
    end else if (!stall) begin
      out_valid <= v1;
      if (v1) begin
        Sum  <= res;
        Ovfl <= ovf;
        Zero <= (res == '0);
        Neg  <= res[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe at WIDTH=16: directed vector
// table, stall/reset sequences, and randomized streams against a model.
module tb_cla_addsub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         stall;
  logic [1:0]   mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic [W-1:0] Sum;
  logic         Ovfl;
  logic         Zero;
  logic         Neg;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .mode(mode),
    .A(A), .B(B), .out_valid(out_valid), .Sum(Sum), .Ovfl(Ovfl),
    .Zero(Zero), .Neg(Neg)
  );

  typedef struct {
    logic [15:0] sum;
    logic        ovfl;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    res_t        exp;
  } vec_t;

  int checks = 0;
  int passed = 0;

  // Reference: exact integer sum of A and the wrapped effective B;
  // overflow means the exact value does not fit in 16 signed bits.
  function automatic res_t model(input logic [1:0] m, input logic [15:0] a,
                                 input logic [15:0] b);
    res_t               r;
    int                 bi;
    logic signed [15:0] eb;
    int                 exact;
    bi    = int'($signed(b));
    eb    = 16'(m[0] ? -bi : bi);
    exact = int'($signed(a)) + int'(eb);
    r.ovfl = (exact > 32767) || (exact < -32768);
    if (m[1] && r.ovfl) r.sum = ($signed(a) < 0) ? 16'h8000 : 16'h7FFF;
    else                r.sum = 16'(exact);
    r.zero = (r.sum == 16'h0000);
    r.neg  = r.sum[15];
    return r;
  endfunction

  function automatic res_t mk(input logic [15:0] s, input logic o,
                              input logic z, input logic n);
    res_t r;
    r.sum = s; r.ovfl = o; r.zero = z; r.neg = n;
    return r;
  endfunction

  task automatic check_out(input string name, input logic ev, input res_t e);
    checks++;
    if (out_valid === ev && Sum === e.sum && Ovfl === e.ovfl &&
        Zero === e.zero && Neg === e.neg) begin
      passed++;
    end else begin
      $display("FAIL %s: got v=%b sum=%h ovfl=%b zero=%b neg=%b, expected v=%b sum=%h ovfl=%b zero=%b neg=%b",
               name, out_valid, Sum, Ovfl, Zero, Neg, ev, e.sum, e.ovfl, e.zero, e.neg);
    end
  endtask

  vec_t vecs[12];
  res_t zero_r;
  res_t seq_exp[7];
  logic seq_v[7];

  initial begin
    zero_r = mk(16'h0000, 1'b0, 1'b0, 1'b0);
    vecs[0]  = '{"add_7fff_1",     2'b00, 16'h7FFF, 16'h0001, mk(16'h8000, 1, 0, 1)};
    vecs[1]  = '{"satadd_7fff_1",  2'b10, 16'h7FFF, 16'h0001, mk(16'h7FFF, 1, 0, 0)};
    vecs[2]  = '{"satsub_8000_1",  2'b11, 16'h8000, 16'h0001, mk(16'h8000, 1, 0, 1)};
    vecs[3]  = '{"sub_equal",      2'b01, 16'h1234, 16'h1234, mk(16'h0000, 0, 1, 0)};
    vecs[4]  = '{"add_half_carry", 2'b00, 16'h00FF, 16'h0001, mk(16'h0100, 0, 0, 0)};
    vecs[5]  = '{"sub_0_min",      2'b01, 16'h0000, 16'h8000, mk(16'h8000, 0, 0, 1)};
    vecs[6]  = '{"sub_m1_min",     2'b01, 16'hFFFF, 16'h8000, mk(16'h7FFF, 1, 0, 0)};
    vecs[7]  = '{"satsub_m1_min",  2'b11, 16'hFFFF, 16'h8000, mk(16'h8000, 1, 0, 1)};
    vecs[8]  = '{"satadd_neg",     2'b10, 16'h8000, 16'hFFFF, mk(16'h8000, 1, 0, 1)};
    vecs[9]  = '{"add_wrap_zero",  2'b00, 16'hFFFF, 16'h0001, mk(16'h0000, 0, 1, 0)};
    vecs[10] = '{"satadd_small",   2'b10, 16'h0001, 16'h0002, mk(16'h0003, 0, 0, 0)};
    vecs[11] = '{"sub_negative",   2'b01, 16'h0005, 16'h0007, mk(16'hFFFE, 0, 0, 1)};

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; mode = 2'b00; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset_state", 1'b0, zero_r);
    rst = 1'b0;

    // Directed table: one op, check two edges later.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; mode = vecs[i].mode; A = vecs[i].a; B = vecs[i].b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_out(vecs[i].name, 1'b1, vecs[i].exp);
    end
    @(negedge clk);
    @(negedge clk);
    check_out("bubble_holds", 1'b0, vecs[11].exp);

    // Back-to-back adds with a two-cycle stall after the second is accepted.
    seq_v[0] = 1'b0; seq_exp[0] = vecs[11].exp;
    seq_v[1] = 1'b1; seq_exp[1] = mk(16'h0002, 0, 0, 0);
    seq_v[2] = 1'b1; seq_exp[2] = mk(16'h0002, 0, 0, 0);
    seq_v[3] = 1'b1; seq_exp[3] = mk(16'h0002, 0, 0, 0);
    seq_v[4] = 1'b1; seq_exp[4] = mk(16'h0004, 0, 0, 0);
    seq_v[5] = 1'b1; seq_exp[5] = mk(16'h0006, 0, 0, 0);
    seq_v[6] = 1'b0; seq_exp[6] = mk(16'h0006, 0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      stall = (c == 2 || c == 3);
      in_valid = (c <= 4);
      mode = 2'b00;
      A = (c == 0) ? 16'd1 : (c == 1) ? 16'd2 : 16'd3;
      B = A;
      @(posedge clk);
      @(negedge clk);
      check_out($sformatf("stall_seq_%0d", c), seq_v[c], seq_exp[c]);
    end
    stall = 1'b0; in_valid = 1'b0;

    // Reset discards an in-flight op.
    in_valid = 1'b1; mode = 2'b00; A = 16'h0005; B = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_out($sformatf("reset_flush_%0d", c), 1'b0, zero_r);
      stall = 1'b0;
    end
    rst = 1'b0;

    // First op after reset appears two edges later.
    in_valid = 1'b1; mode = 2'b00; A = 16'h0011; B = 16'h0022;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("post_reset_lat1", 1'b0, zero_r);
    @(posedge clk);
    @(negedge clk);
    check_out("post_reset_lat2", 1'b1, mk(16'h0033, 0, 0, 0));

    // Randomized streams per mode with bubbles and stalls.
    for (int m = 0; m < 4; m++) begin
      logic p1v;
      logic outv;
      res_t p1r;
      res_t last;
      res_t cur;
      int   acc;
      int   cyc;
      rst = 1'b1; in_valid = 1'b0; stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      p1v = 1'b0; outv = 1'b0; p1r = zero_r; last = zero_r;
      acc = 0; cyc = 0;
      while ((acc < 512 || p1v || outv) && cyc < 4000) begin
        if (cyc > 0) check_out($sformatf("rand_m%0d_c%0d", m, cyc), outv, last);
        stall    = ($urandom_range(0, 7) == 0);
        in_valid = (acc < 512) && ($urandom_range(0, 5) != 0);
        mode     = 2'(m);
        A        = 16'($urandom);
        B        = 16'($urandom);
        if ($urandom_range(0, 15) == 0) B = 16'h8000;
        if ($urandom_range(0, 15) == 0) A = B;
        cur = model(mode, A, B);
        @(posedge clk);
        if (!stall) begin
          if (p1v) last = p1r;
          outv = p1v;
          p1v  = in_valid;
          p1r  = cur;
          if (in_valid) acc++;
        end
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (acc == 512 && cyc < 4000) passed++;
      else $display("FAIL rand_budget_m%0d: got %0d ops in %0d cycles, expected 512 ops within 4000", m, acc, cyc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 8 and at least 8 (each half is built from 4-bit CLA blocks).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  A/B/mode are valid this cycle.
REQ-005 stall  input  1  hold the entire pipeline when high.
REQ-006 mode  input  2  operation: 00 ADD, 01 SUB, 10 SATADD, 11 SATSUB.
REQ-007 A  input  WIDTH  signed operand A.
REQ-008 B  input  WIDTH  signed operand B.
REQ-009 out_valid  output  1  Sum and flags are valid.
REQ-010 Sum  output  WIDTH  signed result.
REQ-011 Ovfl  output  1  raw two's-complement overflow of the unsaturated operation.
REQ-012 Zero  output  1  Sum equals 0.
REQ-013 Neg  output  1  Sum MSB.

Function
REQ-014 The datapath SHALL be a 2-stage pipeline with fixed latency 2: an operation accepted at edge N SHALL appear on the outputs after edge N+1.
REQ-015 Stage 1 SHALL compute the lower WIDTH/2 bits with carry lookahead (B inverted, carry-in 1 for SUB/SATSUB) and register the lower sum, the carry-out, the upper operand halves, the mode, and valid.
REQ-016 Stage 2 SHALL compute the upper half using the registered carry, then apply saturation and register Sum, Ovfl, Zero, Neg, and out_valid.
REQ-017 Ovfl SHALL be 1 exactly when the effective operands share a sign and the raw result sign differs from it (effective B is ~B+1 for subtraction).
REQ-018 ADD/SUB: Sum SHALL equal the raw result modulo 2^WIDTH (wrap-around), with Ovfl still reported.
REQ-019 SATADD/SATSUB with Ovfl=1: Sum SHALL be 0111..1 if A is non-negative, else 1000..0; Ovfl SHALL remain 1.
REQ-020 Zero and Neg SHALL be derived from the final (post-saturation) Sum.
REQ-021 When stall=1 and rst=0, no stage register SHALL change; in_valid that cycle SHALL be ignored (no capture), and the outputs SHALL hold their values.
REQ-022 When in_valid=0 and stall=0, a bubble SHALL propagate: the stage valid SHALL be 0, and out_valid SHALL be 0 two edges later.
REQ-023 When out_valid=0, Sum/flags SHALL hold their last value; consumers SHALL ignore them.
REQ-024 Back-to-back in_valid every cycle SHALL sustain throughput of 1 op/cycle with no inter-operation interference.
REQ-025 SUB of the most-negative B (e.g. A - 0x8000) SHALL follow REQ-017 without special casing.

Reset
REQ-026 rst=1 at a rising edge SHALL clear both stage valid bits, out_valid, Sum, Ovfl, Zero, and Neg to 0; rst SHALL take priority over stall.
REQ-027 Operations in flight when rst is asserted SHALL be discarded and never appear on the outputs.
REQ-028 The first operation accepted in the cycle after rst deasserts SHALL produce out_valid 2 edges later.

Verification (WIDTH=16)
REQ-029 ADD, A=0x7FFF, B=0x0001 -> 2 cycles later Sum=0x8000, Ovfl=1, Neg=1, Zero=0, out_valid=1.
REQ-030 SATADD, A=0x7FFF, B=0x0001 -> Sum=0x7FFF, Ovfl=1, Neg=0; SATSUB, A=0x8000, B=0x0001 -> Sum=0x8000, Ovfl=1.
REQ-031 SUB, A=0x1234, B=0x1234 -> Sum=0x0000, Zero=1, Ovfl=0; ADD, A=0x00FF, B=0x0001 -> Sum=0x0100 (cross-half carry).
REQ-032 Three back-to-back ADDs (1+1, 2+2, 3+3), with stall=1 for 2 cycles after the second is accepted -> outputs 0x0002, 0x0004, 0x0006 in order, each exactly once, with the output held during the stall.
REQ-033 Accept 0x0005+0x0003, then assert rst the next cycle -> out_valid stays 0 and 0x0008 never appears; all outputs read 0.
REQ-034 512 random A/B per mode, checked against a signed reference model (wrap, saturate, flags) at latency 2 -> no mismatches.
